uart_tx_fifo: RTL

Parametrised UART transmitter with an integrated transmit FIFO and prefetch holding register. It serialises words of 5 to DATA_W bits with optional parity and 1 or 2 stop bits, and sends back-to-back frames with no idle gap between them. It sits in the UART subsystem between the APB register file (write side) and the pad (tx). It is paced by the shared baud generator's one-clock `baud_pulse`.

---
 rtl/uart_tx_fifo.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a transmit FIFO and a one-word prefetch holding register.
// Line-break support is compiled in when the macro UART_TX_BREAK_EN is defined.
module uart_tx_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int FIFO_AW    = $clog2(FIFO_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              baud_pulse,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [3:0]        num_bits,
    input  logic              parity_en,
    input  logic              odd_n_even,
    input  logic              two_stop,
    input  logic              break_req,
    output logic              tx,
    output logic              txrdy,
    output logic              fifo_empty,
    output logic [FIFO_AW:0]  fifo_level,
    output logic              busy,
    output logic              overflow
);

`ifdef UART_TX_BREAK_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, BREAK} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;
`endif

    localparam logic [FIFO_AW:0]   FULL_CNT = (FIFO_AW+1)'(FIFO_DEPTH);
    localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW+1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);
    localparam logic [3:0]         NB_MAX   = 4'(DATA_W);

    logic [DATA_W-1:0]  mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;
    logic [FIFO_AW:0]   count_next;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;

    logic [DATA_W-1:0]  hold;
    logic               hold_vld;
    logic               take;

    state_t             state;
    state_t             state_next;
    logic               tx_next;
    logic [DATA_W-1:0]  shift;
    logic [DATA_W-1:0]  shift_next;
    logic [3:0]         bit_cnt;
    logic [3:0]         bit_cnt_next;
    logic               par;
    logic               par_next;
    logic [3:0]         nb_eff;
    logic               cur_bit;
    logic               frame_start;
    logic               brk_gate;

    assign full       = (count == FULL_CNT);
    assign empty      = (count == '0);
    assign push       = wr_en && !full;
    // A pop needs a non-empty FIFO, so a push into an empty FIFO is never popped the same cycle.
    assign pop        = !hold_vld && !empty;
    assign fifo_empty = empty;
    assign fifo_level = count;
    assign busy       = (state != IDLE) || hold_vld;

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CNT_ONE;
            2'b01:   count_next = count - CNT_ONE;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            txrdy    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            count    <= count_next;
            txrdy    <= (count_next != FULL_CNT);
            overflow <= wr_en && full;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
        if (pop)  hold <= mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (reset)     hold_vld <= 1'b0;
        else if (pop)  hold_vld <= 1'b1;
        else if (take) hold_vld <= 1'b0;
    end

    assign nb_eff = (num_bits < 4'd5 || num_bits > NB_MAX) ? NB_MAX : num_bits;

`ifdef UART_TX_BREAK_EN
    assign brk_gate = break_req;
`else
    logic unused_break;
    assign brk_gate     = 1'b0;
    assign unused_break = break_req;
`endif

    always_comb begin
        cur_bit = 1'b0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            if (4'(i) == bit_cnt) cur_bit = shift[i];
        end
    end

    always_comb begin
        state_next   = state;
        tx_next      = tx;
        shift_next   = shift;
        bit_cnt_next = bit_cnt;
        par_next     = par;
        take         = 1'b0;
        frame_start  = 1'b0;
        if (baud_pulse) begin
            case (state)
                IDLE:  frame_start = 1'b1;
                START: begin
                    tx_next      = shift[0];
                    bit_cnt_next = 4'd1;
                    par_next     = shift[0];
                    state_next   = DATA;
                end
                DATA: begin
                    if (bit_cnt < nb_eff) begin
                        tx_next      = cur_bit;
                        par_next     = par ^ cur_bit;
                        bit_cnt_next = bit_cnt + 4'd1;
                    end else if (parity_en) begin
                        tx_next    = par ^ odd_n_even;
                        state_next = PARITY;
                    end else begin
                        tx_next    = 1'b1;
                        state_next = STOP1;
                    end
                end
                PARITY: begin
                    tx_next    = 1'b1;
                    state_next = STOP1;
                end
                STOP1: begin
                    if (two_stop) state_next = STOP2;
                    else          frame_start = 1'b1;
                end
                STOP2: frame_start = 1'b1;
`ifdef UART_TX_BREAK_EN
                BREAK: begin
                    if (!break_req) begin
                        tx_next    = 1'b1;
                        state_next = STOP1;
                    end
                end
`endif
                default: state_next = IDLE;
            endcase

            // IDLE and end-of-frame share one launch decision so frames run back-to-back.
            if (frame_start) begin
                tx_next    = 1'b1;
                state_next = IDLE;
                if (brk_gate) begin
`ifdef UART_TX_BREAK_EN
                    tx_next    = 1'b0;
                    state_next = BREAK;
`endif
                end else if (hold_vld) begin
                    shift_next = hold;
                    take       = 1'b1;
                    tx_next    = 1'b0;
                    state_next = START;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            tx      <= 1'b1;
            shift   <= '0;
            bit_cnt <= '0;
            par     <= 1'b0;
        end else begin
            state   <= state_next;
            tx      <= tx_next;
            shift   <= shift_next;
            bit_cnt <= bit_cnt_next;
            par     <= par_next;
        end
    end

endmodule
